// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : requester, fill-control and memory-side bundle  (rev 1.0)
// ============================================================================
interface dmem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          p_req;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_gnt;
  logic          p_stall;
  logic [DW-1:0] p_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;

  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do;

  // Environment side: requesters, fill control and the memory itself
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_gnt, p_stall, p_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rdata,
    output fill_start, fill_value,
    input  fill_busy, fill_done,
    input  mem_we, mem_addr, mem_di,
    output mem_do
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_gnt, p_stall, p_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rdata,
    input  fill_start, fill_value,
    output fill_busy, fill_done,
    output mem_we, mem_addr, mem_di,
    input  mem_do
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : P/D arbiter with starvation guard and memory fill sequencer
// rev 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus
);

  localparam logic [0:0]    c_ST_IDLE = 1'b0;
  localparam logic [0:0]    c_ST_FILL = 1'b1;
  localparam logic [2:0]    c_WMAX    = 3'(MAX_WAIT);
  localparam logic [AW-1:0] c_LAST    = '1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fval_q, fval_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] p_rdata_q, p_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          fill_done_q, fill_done_d;

  logic          w_force_d;
  logic          w_p_gnt;
  logic          w_d_gnt;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_di;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (bus.fill_start) state_d = c_ST_FILL;
      c_ST_FILL: if (cnt_q == c_LAST) state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // Output logic; grants are gated by rst_n so no write can slip through reset
  always_comb begin
    w_force_d  = bus.d_req && (wcnt_q == c_WMAX);
    w_p_gnt    = 1'b0;
    w_d_gnt    = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_di   = '0;
    case (state_q)
      c_ST_IDLE: begin
        w_p_gnt = rst_n && bus.p_req && !w_force_d;
        w_d_gnt = rst_n && bus.d_req && (!bus.p_req || w_force_d);
        if (w_p_gnt) begin
          w_mem_we   = bus.p_we;
          w_mem_addr = bus.p_addr;
          w_mem_di   = bus.p_wdata;
        end else if (w_d_gnt) begin
          w_mem_we   = bus.d_we;
          w_mem_addr = bus.d_addr;
          w_mem_di   = bus.d_wdata;
        end
      end
      c_ST_FILL: begin
        w_mem_we   = rst_n;
        w_mem_addr = cnt_q;
        w_mem_di   = fval_q;
      end
      default: ;
    endcase
  end

  // Datapath next values: fill counter, wait counter, read capture
  always_comb begin
    cnt_d       = cnt_q;
    fval_d      = fval_q;
    wcnt_d      = wcnt_q;
    fill_done_d = 1'b0;
    p_rdata_d   = (w_p_gnt && !bus.p_we) ? bus.mem_do : p_rdata_q;
    d_rdata_d   = (w_d_gnt && !bus.d_we) ? bus.mem_do : d_rdata_q;
    if (state_q == c_ST_IDLE) begin
      if (bus.fill_start) begin
        cnt_d  = '0;
        fval_d = bus.fill_value;
      end
      if (bus.d_req && !w_d_gnt)
        wcnt_d = (wcnt_q == c_WMAX) ? wcnt_q : wcnt_q + 3'd1;
      else
        wcnt_d = 3'd0;
    end else begin
      // Counter wraps to 0 on the last write, in step with the return to IDLE
      cnt_d       = cnt_q + AW'(1);
      fill_done_d = (cnt_q == c_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      fval_q      <= '0;
      wcnt_q      <= 3'd0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      fill_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fval_q      <= fval_d;
      wcnt_q      <= wcnt_d;
      p_rdata_q   <= p_rdata_d;
      d_rdata_q   <= d_rdata_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign bus.p_gnt     = w_p_gnt;
  assign bus.p_stall   = bus.p_req && !w_p_gnt;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.fill_busy = (state_q == c_ST_FILL);
  assign bus.fill_done = fill_done_q;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_di    = w_mem_di;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed stimulus with per-cycle expected-output scoreboard
// rev 1.0
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(4), .DW(4)) bus ();

  dmem_arbiter #(.AW(4), .DW(4), .MAX_WAIT(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: loads mem[i]=i on the first edge, then follows mem_we
  logic [3:0] mem [16];
  logic       mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_di;
    end
  end
  assign bus.mem_do = mem[bus.mem_addr];

  // Packed view: pg dg ps we addr[4] di[4] busy done prd[4] drd[4]
  localparam logic [21:0] MFULL = 22'h3FFFFF;
  localparam logic [21:0] MRST  = 22'h0403FF;

  typedef struct {
    string       name;
    logic [21:0] v;
    logic [21:0] m;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_prd, exp_drd;

  always @(negedge clk) begin
    exp_t        e;
    logic [21:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {bus.p_gnt, bus.d_gnt, bus.p_stall, bus.mem_we, bus.mem_addr,
             bus.mem_di, bus.fill_busy, bus.fill_done, bus.p_rdata, bus.d_rdata};
      checks++;
      if (((act ^ e.v) & e.m) != 22'h0) begin
        errors++;
        $display("FAIL %s: actual=%06h required=%06h (mask %06h)",
                 e.name, act, e.v, e.m);
      end
    end
  end

  task automatic step(input string nm, input logic pg, dg, ps, we,
                      input logic [3:0] ad, di, input logic busy, done,
                      input logic [21:0] m);
    exp_t e;
    e.name = nm;
    e.v    = {pg, dg, ps, we, ad, di, busy, done, exp_prd, exp_drd};
    e.m    = m;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.fill_start = 0; bus.fill_value = 0;
    exp_prd = 4'h0; exp_drd = 4'h0;
    @(posedge clk); #1;

    step("rst_idle", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    bus.p_req = 1; bus.p_we = 1; bus.p_addr = 4'h3; bus.p_wdata = 4'hA;
    step("rst_we_blocked", 0,0,0,0, 4'h0,4'h0, 0,0, MRST);

    // P write 0xA to 3, then read it back
    rst_n = 1'b1;
    step("p_write", 1,0,0,1, 4'h3,4'hA, 0,0, MFULL);
    bus.p_we = 0; bus.p_wdata = 4'h0;
    step("p_read", 1,0,0,0, 4'h3,4'h0, 0,0, MFULL);
    exp_prd = 4'hA;
    bus.p_req = 0;
    step("p_rdata", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);

    // Contention: D forced through every 4th cycle
    bus.p_req = 1; bus.p_addr = 4'h1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 4'h2;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) begin
        step("contend_d", 0,1,1,0, 4'h2,4'h0, 0,0, MFULL);
        exp_drd = 4'h2;
      end else begin
        step("contend_p", 1,0,0,0, 4'h1,4'h0, 0,0, MFULL);
        exp_prd = 4'h1;
      end
    end
    bus.p_req = 0; bus.d_req = 0;
    step("contend_end", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);

    // D alone: write 0x5 to 15, read it back
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 4'hF; bus.d_wdata = 4'h5;
    step("d_write", 0,1,0,1, 4'hF,4'h5, 0,0, MFULL);
    bus.d_we = 0; bus.d_wdata = 4'h0;
    step("d_read", 0,1,0,0, 4'hF,4'h0, 0,0, MFULL);
    exp_drd = 4'h5;
    bus.d_req = 0;
    step("d_rdata", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);

    // Fill with 0x7 while P keeps requesting; the start cycle is still arbitrated
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 4'h0;
    bus.fill_start = 1; bus.fill_value = 4'h7;
    step("fill_start_arb", 1,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    exp_prd = 4'h0;
    bus.fill_start = 0; bus.fill_value = 4'h0;
    for (int k = 0; k < 16; k++) begin
      bus.fill_start = (k == 5);
      step("fill_write", 0,0,1,1, 4'(k),4'h7, 1,0, MFULL);
    end
    bus.fill_start = 0;
    step("fill_done", 1,0,0,0, 4'h0,4'h0, 0,1, MFULL);
    exp_prd = 4'h7;
    for (int a = 0; a < 16; a++) begin
      bus.p_addr = 4'(a);
      step("fill_readback", 1,0,0,0, 4'(a),4'h0, 0,0, MFULL);
      exp_prd = 4'h7;
    end
    bus.p_req = 0; bus.p_addr = 4'h0;
    step("fill_rb_last", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);

    // Fill with 0x3, aborted by reset at fill cycle 8
    bus.fill_start = 1; bus.fill_value = 4'h3;
    step("fill2_start", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    bus.fill_start = 0;
    for (int k = 0; k < 8; k++)
      step("fill2_write", 0,0,0,1, 4'(k),4'h3, 1,0, MFULL);
    rst_n = 1'b0;
    exp_prd = 4'h0; exp_drd = 4'h0;
    step("rst_abort", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    step("rst_hold", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    rst_n = 1'b1;
    step("no_fill_done", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);
    bus.d_req = 1; bus.d_we = 0;
    for (int a = 0; a < 16; a++) begin
      bus.d_addr = 4'(a);
      step("abort_readback", 0,1,0,0, 4'(a),4'h0, 0,0, MFULL);
      exp_drd = (a < 8) ? 4'h3 : 4'h7;
    end
    bus.d_req = 0; bus.d_addr = 4'h0;
    step("abort_rb_last", 0,0,0,0, 4'h0,4'h0, 0,0, MFULL);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
